// File: rtl/bytecode_fetcher.sv
// Variable-length JVM bytecode fetch front-end: reads 1..3 bytes per instruction from byte-wide
// memory, packs them opcode-first and presents them over valid/ready, with branch redirect.
module bytecode_fetcher #(
    parameter int BYTE       = 8,
    parameter int MAX_LEN    = 3,
    parameter int ADDR_WIDTH = 8,
    parameter int OUT_WIDTH  = MAX_LEN * BYTE
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] start_addr_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_rd_o,
    input  logic [BYTE-1:0]       mem_data_i,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    output logic [OUT_WIDTH-1:0]  instr_data_o,
    output logic [1:0]            instr_len_o,
    output logic [ADDR_WIDTH-1:0] instr_pc_o,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_addr_i,
    output logic                  busy_o
);

    typedef enum logic [1:0] {IDLE, REQ, CAPTURE, PRESENT} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [1:0]              idx_q, idx_d;
    logic [1:0]              len_q, len_d;
    logic [OUT_WIDTH-1:0]    word_q, word_d;
    logic [ADDR_WIDTH-1:0]   opPc_q, opPc_d;
    logic                    valid_q, valid_d;
    logic                    memRd_q;
    logic [ADDR_WIDTH-1:0]   memAddr_q;
    logic                    busy_q;
    logic [1:0]              capLen;

    function automatic logic [1:0] opLen(input logic [BYTE-1:0] op);
        if (op inside {8'h11, 8'h84, [8'h99:8'hA8]})
            return 2'd3;
        if (op inside {8'h10, 8'h12, [8'h15:8'h19], [8'h36:8'h3A], 8'hA9, 8'hBC})
            return 2'd2;
        return 2'd1;
    endfunction

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        idx_d   = idx_q;
        len_d   = len_q;
        word_d  = word_q;
        opPc_d  = opPc_q;
        valid_d = valid_q;
        capLen  = len_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    pc_d    = start_addr_i;
                    idx_d   = 2'd0;
                    state_d = REQ;
                end
            end
            REQ: state_d = CAPTURE;
            CAPTURE: begin
                pc_d = pc_q + ADDR_WIDTH'(1);
                // The opcode slot clears the whole word so bytes beyond the length read as zero.
                if (idx_q == 2'd0) begin
                    word_d                     = '0;
                    word_d[OUT_WIDTH-1 -: BYTE] = mem_data_i;
                    opPc_d                     = pc_q;
                    capLen                     = opLen(mem_data_i);
                    len_d                      = capLen;
                end else begin
                    for (int k = 1; k < 3; k++) begin
                        if (idx_q == 2'(k))
                            word_d[OUT_WIDTH-1-k*BYTE -: BYTE] = mem_data_i;
                    end
                end
                if (idx_q + 2'd1 == capLen) begin
                    valid_d = 1'b1;
                    idx_d   = 2'd0;
                    state_d = PRESENT;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = REQ;
                end
            end
            PRESENT: begin
                if (instr_ready_i) begin
                    valid_d = 1'b0;
                    idx_d   = 2'd0;
                    state_d = (word_q[OUT_WIDTH-1 -: BYTE] == 8'hB1) ? IDLE : REQ;
                end
            end
            default: state_d = IDLE;
        endcase

        // Redirect overrides any in-progress work, including a concurrent return transfer.
        if (redirect_i && (state_q != IDLE)) begin
            pc_d    = redirect_addr_i;
            idx_d   = 2'd0;
            valid_d = 1'b0;
            state_d = REQ;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            idx_q     <= '0;
            len_q     <= '0;
            word_q    <= '0;
            opPc_q    <= '0;
            valid_q   <= 1'b0;
            memRd_q   <= 1'b0;
            memAddr_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            word_q  <= word_d;
            opPc_q  <= opPc_d;
            valid_q <= valid_d;
            memRd_q <= (state_d == REQ);
            if (state_d == REQ)
                memAddr_q <= pc_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign mem_addr_o    = memAddr_q;
    assign mem_rd_o      = memRd_q;
    assign instr_valid_o = valid_q;
    assign instr_data_o  = word_q;
    assign instr_len_o   = len_q;
    assign instr_pc_o    = opPc_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_bytecode_fetcher.sv
// Directed and randomized bench for bytecode_fetcher; randomized programs are checked against
// an instruction list built by walking memory with the opcode length rules.
module tb_bytecode_fetcher;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  startAddr = 8'h00;
    logic [7:0]  memAddr;
    logic        memRd;
    logic [7:0]  memData = 8'h00;
    logic        instrValid;
    logic        instrReady = 1'b1;
    logic [23:0] instrData;
    logic [1:0]  instrLen;
    logic [7:0]  instrPc;
    logic        redirect = 1'b0;
    logic [7:0]  redirectAddr = 8'h00;
    logic        busy;

    logic [7:0]  mem [256];
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [23:0] data;
        logic [1:0]  len;
        logic [7:0]  pc;
    } instr_t;
    instr_t expQ[$];

    bytecode_fetcher dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .start_i         (start),
        .start_addr_i    (startAddr),
        .mem_addr_o      (memAddr),
        .mem_rd_o        (memRd),
        .mem_data_i      (memData),
        .instr_valid_o   (instrValid),
        .instr_ready_i   (instrReady),
        .instr_data_o    (instrData),
        .instr_len_o     (instrLen),
        .instr_pc_o      (instrPc),
        .redirect_i      (redirect),
        .redirect_addr_i (redirectAddr),
        .busy_o          (busy)
    );

    always #5 clk = ~clk;

    // Synchronous program memory: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (memRd)
            memData <= mem[memAddr];
    end

    function automatic int refLen(input int op);
        if (op == 'h11 || op == 'h84 || (op >= 'h99 && op <= 'hA8))
            return 3;
        if (op == 'h10 || op == 'h12 || (op >= 'h15 && op <= 'h19) ||
            (op >= 'h36 && op <= 'h3A) || op == 'hA9 || op == 'hBC)
            return 2;
        return 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] addr);
        startAddr = addr;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic waitValid(input string tag);
        int n = 0;
        while (!instrValid && n < 40) begin
            tick();
            n++;
        end
        checkOutput({tag, "_seen"}, 64'(instrValid), 64'd1);
    endtask

    task automatic expectInstr(input string tag, input logic [23:0] d, input logic [1:0] l,
                               input logic [7:0] p);
        waitValid(tag);
        checkOutput({tag, "_data"}, 64'(instrData), 64'(d));
        checkOutput({tag, "_len"}, 64'(instrLen), 64'(l));
        checkOutput({tag, "_pc"}, 64'(instrPc), 64'(p));
        tick();
    endtask

    task automatic loadBytes(input logic [7:0] base, input logic [7:0] b [$]);
        logic [7:0] a = base;
        foreach (b[i]) begin
            mem[a] = b[i];
            a = a + 8'd1;
        end
    endtask

    initial begin
        logic [7:0] addr;
        logic [7:0] op, b1, b2;
        int         len;
        int         n;
        instr_t     e;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        tick();
        tick();
        checkOutput("rst_valid", 64'(instrValid), 64'd0);
        checkOutput("rst_rd", 64'(memRd), 64'd0);
        checkOutput("rst_addr", 64'(memAddr), 64'd0);
        checkOutput("rst_data", 64'(instrData), 64'd0);
        checkOutput("rst_len", 64'(instrLen), 64'd0);
        checkOutput("rst_pc", 64'(instrPc), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        tick();

        // Single-byte stream with explicit latency checks on the first instruction.
        loadBytes(8'h00, '{8'h03, 8'h04, 8'hB1});
        instrReady = 1'b1;
        applyStimulus(8'h00);
        checkOutput("s1_req_rd", 64'(memRd), 64'd1);
        checkOutput("s1_req_addr", 64'(memAddr), 64'h00);
        checkOutput("s1_busy", 64'(busy), 64'd1);
        tick();
        checkOutput("s1_cap_rd", 64'(memRd), 64'd0);
        checkOutput("s1_cap_valid", 64'(instrValid), 64'd0);
        tick();
        checkOutput("s1_lat_valid", 64'(instrValid), 64'd1);
        expectInstr("s1_i0", 24'h030000, 2'd1, 8'h00);
        expectInstr("s1_i1", 24'h040000, 2'd1, 8'h01);
        expectInstr("s1_i2", 24'hB10000, 2'd1, 8'h02);
        checkOutput("s1_idle_busy", 64'(busy), 64'd0);
        checkOutput("s1_idle_rd", 64'(memRd), 64'd0);
        tick();
        tick();
        checkOutput("s1_idle_rd2", 64'(memRd), 64'd0);

        // Variable-length stream.
        loadBytes(8'h10, '{8'h10, 8'h7F, 8'h11, 8'h12, 8'h34, 8'h84, 8'h01, 8'hFF, 8'hB1});
        applyStimulus(8'h10);
        expectInstr("vl_i0", 24'h107F00, 2'd2, 8'h10);
        expectInstr("vl_i1", 24'h111234, 2'd3, 8'h12);
        expectInstr("vl_i2", 24'h8401FF, 2'd3, 8'h15);
        expectInstr("vl_i3", 24'hB10000, 2'd1, 8'h18);
        checkOutput("vl_busy", 64'(busy), 64'd0);

        // Backpressure: held stable with no memory traffic, then exactly one transfer.
        loadBytes(8'h30, '{8'h12, 8'h55, 8'h04, 8'hB1});
        instrReady = 1'b0;
        applyStimulus(8'h30);
        waitValid("bp");
        for (int c = 0; c < 5; c++) begin
            checkOutput("bp_data", 64'(instrData), 64'h125500);
            checkOutput("bp_len", 64'(instrLen), 64'd2);
            checkOutput("bp_pc", 64'(instrPc), 64'h30);
            checkOutput("bp_rd", 64'(memRd), 64'd0);
            checkOutput("bp_valid", 64'(instrValid), 64'd1);
            tick();
        end
        instrReady = 1'b1;
        tick();
        instrReady = 1'b0;
        checkOutput("bp_after_valid", 64'(instrValid), 64'd0);
        checkOutput("bp_next_rd", 64'(memRd), 64'd1);
        checkOutput("bp_next_addr", 64'(memAddr), 64'h32);
        waitValid("bp_i1");
        checkOutput("bp_i1_data", 64'(instrData), 64'h040000);
        checkOutput("bp_i1_pc", 64'(instrPc), 64'h32);
        instrReady = 1'b1;
        tick();
        expectInstr("bp_i2", 24'hB10000, 2'd1, 8'h33);

        // Redirect while the first operand of 0x11 is being captured.
        loadBytes(8'h20, '{8'h11, 8'hAA, 8'hBB, 8'hB1});
        loadBytes(8'h40, '{8'h04, 8'hB1});
        applyStimulus(8'h20);
        tick();
        tick();
        tick();
        checkOutput("rd_cap_rd", 64'(memRd), 64'd0);
        redirect = 1'b1;
        redirectAddr = 8'h40;
        tick();
        redirect = 1'b0;
        checkOutput("rd_valid", 64'(instrValid), 64'd0);
        checkOutput("rd_rd", 64'(memRd), 64'd1);
        checkOutput("rd_addr", 64'(memAddr), 64'h40);
        expectInstr("rd_i0", 24'h040000, 2'd1, 8'h40);
        expectInstr("rd_i1", 24'hB10000, 2'd1, 8'h41);

        // Redirect on the same edge as a transfer.
        loadBytes(8'h48, '{8'h04, 8'h05, 8'hB1});
        loadBytes(8'h50, '{8'h06, 8'hB1});
        instrReady = 1'b0;
        applyStimulus(8'h48);
        waitValid("rx");
        checkOutput("rx_data", 64'(instrData), 64'h040000);
        instrReady = 1'b1;
        redirect = 1'b1;
        redirectAddr = 8'h50;
        tick();
        redirect = 1'b0;
        checkOutput("rx_valid", 64'(instrValid), 64'd0);
        checkOutput("rx_addr", 64'(memAddr), 64'h50);
        expectInstr("rx_i1", 24'h060000, 2'd1, 8'h50);
        expectInstr("rx_i2", 24'hB10000, 2'd1, 8'h51);

        // Return transfer coinciding with redirect keeps fetching.
        loadBytes(8'h60, '{8'hB1});
        loadBytes(8'h70, '{8'h03, 8'hB1});
        instrReady = 1'b0;
        applyStimulus(8'h60);
        waitValid("rr");
        instrReady = 1'b1;
        redirect = 1'b1;
        redirectAddr = 8'h70;
        tick();
        redirect = 1'b0;
        checkOutput("rr_busy", 64'(busy), 64'd1);
        checkOutput("rr_addr", 64'(memAddr), 64'h70);
        expectInstr("rr_i0", 24'h030000, 2'd1, 8'h70);
        expectInstr("rr_i1", 24'hB10000, 2'd1, 8'h71);
        checkOutput("rr_idle", 64'(busy), 64'd0);

        // Address wrap, then reset in the middle of a capture.
        loadBytes(8'hFF, '{8'h10, 8'h05, 8'hB1});
        applyStimulus(8'hFF);
        expectInstr("wr_i0", 24'h100500, 2'd2, 8'hFF);
        checkOutput("wr_req_addr", 64'(memAddr), 64'h01);
        tick();
        checkOutput("wr_cap_rd", 64'(memRd), 64'd0);
        reset = 1'b1;
        tick();
        checkOutput("wr_rst_valid", 64'(instrValid), 64'd0);
        checkOutput("wr_rst_busy", 64'(busy), 64'd0);
        checkOutput("wr_rst_addr", 64'(memAddr), 64'h00);
        checkOutput("wr_rst_rd", 64'(memRd), 64'd0);
        reset = 1'b0;
        tick();
        applyStimulus(8'h01);
        expectInstr("wr_restart", 24'hB10000, 2'd1, 8'h01);
        checkOutput("wr_restart_busy", 64'(busy), 64'd0);

        // Randomized programs with random backpressure.
        for (int r = 0; r < 4; r++) begin
            expQ.delete();
            addr = 8'($urandom_range(0, 255));
            startAddr = addr;
            n = $urandom_range(3, 7);
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 2))
                    0: begin
                        do op = 8'($urandom_range(0, 255)); while (op == 8'hB1);
                    end
                    1: op = 8'h99 + 8'($urandom_range(0, 15));
                    default: op = 8'h36 + 8'($urandom_range(0, 4));
                endcase
                b1 = 8'($urandom_range(0, 255));
                b2 = 8'($urandom_range(0, 255));
                len = refLen(int'(op));
                e.data = {op, (len > 1) ? b1 : 8'h00, (len > 2) ? b2 : 8'h00};
                e.len = 2'(len);
                e.pc = addr;
                expQ.push_back(e);
                mem[addr] = op;
                mem[addr + 8'd1] = b1;
                mem[addr + 8'd2] = b2;
                addr = addr + 8'(len);
            end
            mem[addr] = 8'hB1;
            e.data = 24'hB10000;
            e.len = 2'd1;
            e.pc = addr;
            expQ.push_back(e);

            applyStimulus(startAddr);
            for (int c = 0; c < 800 && (expQ.size() > 0 || busy); c++) begin
                instrReady = 1'($urandom_range(0, 1));
                if (instrValid && instrReady) begin
                    if (expQ.size() == 0) begin
                        checkOutput("rand_extra_valid", 64'(instrValid), 64'd0);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("rand_data", 64'(instrData), 64'(e.data));
                        checkOutput("rand_len", 64'(instrLen), 64'(e.len));
                        checkOutput("rand_pc", 64'(instrPc), 64'(e.pc));
                    end
                end
                tick();
            end
            checkOutput("rand_drained", 64'(expQ.size()), 64'd0);
            checkOutput("rand_idle", 64'(busy), 64'd0);
        end
        instrReady = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bytecode_fetcher.md
Name: bytecode_fetcher

Overview:
Parametrised instruction fetch front-end for the JVM bytecode datapath. Walks byte-wide program memory from a start address and determines each instruction's length from its opcode. Assembles opcode plus operand bytes into one packed word and hands it to the decoder over a valid/ready handshake. Adds what the fixed 2-byte fetcher lacks: variable length (1..3 bytes), a parametrised output width, branch redirect, PC reporting and automatic stop on `return`.

Parameters:
BYTE, 8, bits per memory byte
MAX_LEN, 3, maximum instruction bytes held in the output word; must be >= 3
ADDR_WIDTH, 8, program-memory address width
OUT_WIDTH, MAX_LEN*BYTE, packed instruction width (derived; do not override)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
start  in  1  begin fetching at start_addr; honoured only in IDLE
start_addr  in  ADDR_WIDTH  first instruction address
mem_addr  out  ADDR_WIDTH  program-memory byte address
mem_rd  out  1  read strobe; memory returns mem_data on the next cycle
mem_data  in  BYTE  read data, valid the cycle after mem_rd
instr_valid  out  1  packed instruction available
instr_ready  in  1  decoder accepts the instruction
instr_data  out  OUT_WIDTH  opcode in [OUT_WIDTH-1 -: BYTE], then operands in descending byte order; unused bytes are 0
instr_len  out  2  byte count of the presented instruction (1..3)
instr_pc  out  ADDR_WIDTH  address of the opcode byte
redirect  in  1  branch taken; restart fetch at redirect_addr
redirect_addr  in  ADDR_WIDTH  branch target
busy  out  1  high in any state other than IDLE

Behaviour:
- States: IDLE, REQ, CAPTURE, PRESENT. All outputs are registered.
- Reset: state=IDLE, pc=0, byte count=0. Outputs on reset: mem_rd=0, mem_addr=0, instr_valid=0, instr_data=0, instr_len=0, instr_pc=0, busy=0.
- IDLE:
  - start=1 -> pc=start_addr, go to REQ.
  - start is ignored in every other state.
- REQ (1 cycle):
  - mem_addr=pc, mem_rd=1.
  - Next state is CAPTURE.
- CAPTURE (1 cycle):
  - mem_rd=0. mem_data is latched into byte slot idx, and pc increments.
  - For idx=0 (opcode): instr_pc = pre-increment pc, and length L comes from the table below.
  - If more bytes remain, go to REQ; otherwise go to PRESENT with instr_valid=1.
- Byte timing: 2 cycles per byte. Start-to-valid latency is 2L cycles.
- Length table (all other opcodes L=1):
  - L=2: 0x10, 0x12, 0x15-0x19, 0x36-0x3A, 0xA9, 0xBC.
  - L=3: 0x11, 0x84, 0x99-0xA8.
- PRESENT: hold instr_valid, instr_data, instr_len and instr_pc stable until instr_valid && instr_ready.
  - On transfer: clear idx and go to REQ in the following cycle.
  - If the transferred opcode is 0xB1 (return), go to IDLE instead.
- Address arithmetic: pc is modulo 2^ADDR_WIDTH. An instruction may span the wrap (0xFF -> 0x00) with no error.
- Redirect (priority over everything except reset, in any non-IDLE state):
  - Next cycle: pc=redirect_addr, idx=0, instr_valid=0, go to REQ.
  - Partial instruction bytes are discarded; an in-flight memory read is dropped.
  - Redirect in IDLE is ignored.
- Redirect and transfer in the same cycle (valid && ready && redirect): the transfer counts as completed; fetch resumes at redirect_addr.
- A 0xB1 transfer with simultaneous redirect: redirect wins and the block does not go to IDLE.
- Reset mid-operation: immediate return to reset values. Partial instruction lost; instr_valid drops in the same edge.
- instr_ready while instr_valid=0 has no effect. instr_data bytes beyond L are forced to 0.

Test Plan:
- Single-byte stream: memory[0x00..]=0x03,0x04,0xB1, start_addr=0x00, ready held 1 -> three transfers with data 0x030000/0x040000/0xB10000, len=1, pc=0x00/0x01/0x02, each valid 2 cycles after the request begins; after 0xB1, busy=0 and mem_rd stays 0.
- Variable length: memory at 0x10 = 0x10,0x7F,0x11,0x12,0x34,0x84,0x01,0xFF,0xB1 -> words 0x107F00 len2 pc0x10, 0x111234 len3 pc0x12, 0x8401FF len3 pc0x15, 0xB10000 len1 pc0x18.
- Backpressure: ready=0 for 5 cycles while valid -> instr_data/len/pc stay constant, mem_rd=0 throughout; raise ready -> exactly one transfer, next REQ at pc+len.
- Redirect mid-fetch: while capturing the operand of 0x11 at 0x20, pulse redirect with redirect_addr=0x40 (memory[0x40]=0x04) -> no instruction from 0x20 emitted; next transfer is 0x040000 pc=0x40.
- Redirect coincident with transfer: valid, ready=1 and redirect=1 (target 0x50) on the same cycle -> instruction counted as transferred once; next mem_addr=0x50.
- Wrap and reset: start_addr=0xFF with memory[0xFF]=0x10, memory[0x00]=0x05 -> word 0x100500 pc=0xFF; then assert reset during CAPTURE -> valid=0, busy=0, mem_addr=0 on the next edge; start is honoured afterwards.
